button_debounce: RTL and testbench

- Input-side counterpart to the board LED path: conditions a raw, asynchronous user pin (button on TinyFPGA BX header) into clean, clock-domain-safe signals for the SoC.
- Two-flop synchroniser, debounce counter, stable level, single-cycle press/release pulses, 32-bit press counter readable by the SoC.
- Sits in the board top level between the pin and the QuSoC top-level module, on the 16 MHz CLK.

---
 rtl/button_debounce_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/button_debounce.sv | 88 ++++++++
 tb/tb_button_debounce.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// rtl/button_debounce_pkg.sv - shared constants and width helper for board input conditioning
//
// Purpose : constants shared by the button debouncer and future board-input
//           conditioning blocks.
// Contents: DEBOUNCE_DEFAULT - default debounce length in clock cycles
//                              (1 ms at CLK_HZ)
//           CLK_HZ           - board system clock frequency
//           debounce_width() - width of a counter that must reach cycles-1,
//                              never less than one bit
package button_debounce_pkg;

    localparam int DEBOUNCE_DEFAULT = 16000;
    localparam int CLK_HZ           = 16000000;

    // A counter that must reach cycles-1 needs clog2(cycles) bits.
    // A single-cycle debounce still needs one bit to hold zero.
    function automatic int debounce_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with synchronous reset
//
// Purpose : brings one asynchronous board input into the clk domain. The
//           input feeds the first flop directly, with no logic in front of it.
// Ports   : clk - destination clock
//           rst - synchronous active-high reset, clears both stages
//           d   - asynchronous input
//           q   - synchronised output, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronised, debounced button with press/release pulses and press counter
//
// Purpose : conditions the raw button pin for the SoC. It provides a clean
//           level, one-cycle press/release pulses, and a count of presses.
// Ports   : Clock      - system clock
//           Reset      - synchronous active-high reset; overrides all other inputs
//           PinIn      - raw asynchronous pin, pressed = 1
//           ClearCount - synchronous request to zero PressCount
//           Level      - debounced level
//           Rise       - one-cycle pulse when Level becomes 1
//           Fall       - one-cycle pulse when Level becomes 0
//           PressCount - number of Rise pulses since reset or the last clear;
//                        wraps silently
// All outputs are registered, so no input reaches an output combinationally.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   PinIn,
    input  logic                   ClearCount,
    output logic                   Level,
    output logic                   Rise,
    output logic                   Fall,
    output logic [COUNT_WIDTH-1:0] PressCount
);

    localparam int CNT_W = debounce_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pin_sync;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             expire;
    logic             press;

    sync_2ff u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (PinIn),
        .q   (pin_sync)
    );

    // The counter holds the number of consecutive edges on which the
    // synchronised pin has already disagreed with Level. Level flips on the
    // edge where the current disagreement completes a run of
    // DEBOUNCE_CYCLES disagreeing edges. The flip edge is also the edge
    // that registers the matching pulse.
    always_comb begin
        differ = (pin_sync != Level);
        expire = differ && (cnt == CNT_LAST);
        press  = expire && pin_sync;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt        <= '0;
            Level      <= 1'b0;
            Rise       <= 1'b0;
            Fall       <= 1'b0;
            PressCount <= '0;
        end else begin
            if (!differ || expire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (expire) begin
                Level <= pin_sync;
            end

            Rise <= press;
            Fall <= expire && !pin_sync;

            // A clear on the same edge as a press still records that press.
            if (ClearCount) begin
                PressCount <= COUNT_WIDTH'(press);
            end else begin
                PressCount <= PressCount + COUNT_WIDTH'(press);
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// tb/tb_button_debounce.sv - self-checking bench for button_debounce with a window-based reference model
module tb_button_debounce;

    localparam int DB = 4;
    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          PinIn;
    logic          ClearCount;
    logic          Level;
    logic          Rise;
    logic          Fall;
    logic [CW-1:0] PressCount;

    always #5 Clock = ~Clock;

    button_debounce #(
        .DEBOUNCE_CYCLES (DB),
        .COUNT_WIDTH     (CW)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .PinIn      (PinIn),
        .ClearCount (ClearCount),
        .Level      (Level),
        .Rise       (Rise),
        .Fall       (Fall),
        .PressCount (PressCount)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model. The pin value sampled at post-reset edge e is stored
    // as hist[e]. The synchronised pin seen at edge e is therefore hist[e-2],
    // or 0 for the first two edges. Level flips at edge e when the
    // synchronised pin disagreed with Level on each of the last DB edges.
    // All of those edges must come after the previous flip.
    bit hist[$];
    int k;
    int last_flip;
    bit m_level;
    bit m_rise;
    bit m_fall;
    int m_count;

    function automatic bit s2_at(input int e);
        return (e >= 2) ? hist[e-2] : 1'b0;
    endfunction

    task automatic model_edge(input bit rst, input bit pin, input bit clr);
        bit flip;
        if (rst) begin
            hist.delete();
            k         = 0;
            last_flip = -1;
            m_level   = 1'b0;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_count   = 0;
        end else begin
            hist.push_back(pin);
            flip = (k - DB + 1 > last_flip);
            if (flip) begin
                for (int j = k - DB + 1; j <= k; j++) begin
                    if (s2_at(j) == m_level) flip = 1'b0;
                end
            end
            m_rise = flip && !m_level;
            m_fall = flip && m_level;
            if (flip) begin
                m_level   = !m_level;
                last_flip = k;
            end
            if (clr) m_count = int'(m_rise);
            else     m_count = (m_count + int'(m_rise)) % (1 << CW);
            k++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit pin, input bit clr);
        Reset      = rst;
        PinIn      = pin;
        ClearCount = clr;
        @(posedge Clock);
        #1;
        model_edge(rst, pin, clr);
        chk("level", 32'(Level), 32'(m_level));
        chk("rise", 32'(Rise), 32'(m_rise));
        chk("fall", 32'(Fall), 32'(m_fall));
        chk("press_count", 32'(PressCount), 32'(m_count));
        chk("rise_fall_exclusive", 32'(Rise && Fall), 32'd0);
    endtask

    task automatic press_release(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < lo; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int e0;
        int found;
        int r_cnt;
        int f_cnt;
        bit pin;
        int run;

        Reset      = 1'b1;
        PinIn      = 1'b0;
        ClearCount = 1'b0;

        // Reset held for three cycles with the pin low.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("reset_level", 32'(Level), 32'd0);
        chk("reset_count", 32'(PressCount), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

        // Press latency: the edge that captures the pin, plus DB+1 edges.
        e0 = k;
        found = -1;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (Rise && found < 0) found = k - 1;
        end
        chk("press_latency", 32'(found - e0), 32'(DB + 1));
        chk("first_press_count", 32'(PressCount), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("released_level", 32'(Level), 32'd0);

        // Glitches shorter than DB cycles are rejected.
        r_cnt = 0;
        f_cnt = 0;
        for (int g = 0; g < 10; g++) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b1, 1'b0);
                r_cnt += int'(Rise);
                f_cnt += int'(Fall);
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b0, 1'b0, 1'b0);
                r_cnt += int'(Rise);
                f_cnt += int'(Fall);
            end
        end
        chk("glitch_rises", 32'(r_cnt), 32'd0);
        chk("glitch_falls", 32'(f_cnt), 32'd0);
        chk("glitch_count", 32'(PressCount), 32'd1);

        // Three clean press/release cycles.
        r_cnt = 0;
        f_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 16; i++) begin
                step(1'b0, i < 8, 1'b0);
                r_cnt += int'(Rise);
                f_cnt += int'(Fall);
            end
        end
        chk("clean_rises", 32'(r_cnt), 32'd3);
        chk("clean_falls", 32'(f_cnt), 32'd3);
        chk("clean_count", 32'(PressCount), 32'd4);

        // Clear, then seven presses, then a clear that coincides with a press.
        step(1'b0, 1'b0, 1'b1);
        chk("clear_alone", 32'(PressCount), 32'd0);
        for (int p = 0; p < 7; p++) press_release(8, 8);
        chk("seven_presses", 32'(PressCount), 32'd7);
        for (int i = 0; i < DB + 1; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("clear_with_press_rise", 32'(Rise), 32'd1);
        chk("clear_with_press_count", 32'(PressCount), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("clear_after_press", 32'(PressCount), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0);

        // The 4-bit counter wraps from 15 to 0.
        for (int p = 0; p < 15; p++) press_release(8, 8);
        chk("count_at_max", 32'(PressCount), 32'd15);
        press_release(8, 8);
        chk("count_wrapped", 32'(PressCount), 32'd0);

        // Random pin runs with occasional clears.
        pin = 1'b0;
        for (int r = 0; r < 300; r++) begin
            pin = ~pin;
            run = $urandom_range(1, 10);
            for (int i = 0; i < run; i++) begin
                step(1'b0, pin, ($urandom_range(0, 31) == 0));
            end
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("random_settled_level", 32'(Level), 32'd0);

        // Reset in the middle of a debounce with the pin held high.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_reset_level", 32'(Level), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        chk("mid_reset_count", 32'(PressCount), 32'd0);
        found = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (Rise && found < 0) found = k - 1;
        end
        chk("post_reset_rise_edge", 32'(found), 32'(DB + 1));
        chk("post_reset_count", 32'(PressCount), 32'd1);
        chk("post_reset_level", 32'(Level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
